// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the MIPS multicycle controller: FSM states, opcodes,
// ALU and mux select codes.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEM_ADR = 4'd2,
    S_MEM_RD  = 4'd3,
    S_MEM_WB  = 4'd4,
    S_MEM_WR  = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALU_WB  = 4'd7,
    S_BRANCH  = 4'd8,
    S_JUMP    = 4'd9,
    S_ADDI_EX = 4'd10,
    S_ADDI_WB = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [1:0] ALU_OP_ADD  = 2'b00;
  localparam logic [1:0] ALU_OP_SUB  = 2'b01;
  localparam logic [1:0] ALU_OP_FUNC = 2'b10;

  localparam logic [1:0] SRCB_B       = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SL2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  function automatic logic op_is_legal(input logic [5:0] op);
    return op inside {OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI};
  endfunction

endpackage

// File: rtl/mips_ctrl_decode.sv
// Combinational state-to-control decode; all controls forced low while
// the controller is held in reset.
module mips_ctrl_decode
  import mips_ctrl_pkg::*;
(
  input  state_t     state,
  input  logic       active,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       pc_en,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_source,
  output logic [1:0] alu_op,
  output logic       retire,
  output logic       illegal_op
);

  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    reg_dst       = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_B;
    pc_source     = PCSRC_ALU;
    alu_op        = ALU_OP_ADD;
    retire        = 1'b0;
    illegal_op    = 1'b0;
    if (active) begin
      unique case (state)
        S_FETCH: begin
          mem_read  = 1'b1;
          alu_src_b = SRCB_FOUR;
          ir_write  = mem_ready;
          pc_write  = mem_ready;
        end
        S_DECODE: begin
          alu_src_b  = SRCB_IMM_SL2;
          illegal_op = !op_is_legal(opcode);
        end
        S_MEM_ADR, S_ADDI_EX: begin
          alu_src_a = 1'b1;
          alu_src_b = SRCB_IMM;
        end
        S_MEM_RD: begin
          mem_read = 1'b1;
          i_or_d   = 1'b1;
        end
        S_MEM_WB: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
          retire     = 1'b1;
        end
        S_MEM_WR: begin
          mem_write = 1'b1;
          i_or_d    = 1'b1;
          retire    = mem_ready;
        end
        S_EXECUTE: begin
          alu_src_a = 1'b1;
          alu_op    = ALU_OP_FUNC;
        end
        S_ALU_WB: begin
          reg_write = 1'b1;
          reg_dst   = 1'b1;
          retire    = 1'b1;
        end
        S_BRANCH: begin
          alu_src_a     = 1'b1;
          alu_op        = ALU_OP_SUB;
          pc_write_cond = 1'b1;
          pc_source     = PCSRC_ALUOUT;
          retire        = 1'b1;
        end
        S_JUMP: begin
          pc_write  = 1'b1;
          pc_source = PCSRC_JUMP;
          retire    = 1'b1;
        end
        S_ADDI_WB: begin
          reg_write = 1'b1;
          retire    = 1'b1;
        end
        default: ;
      endcase
    end
    pc_en = pc_write | (pc_write_cond & zero);
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM: state register and next-state logic; the
// control outputs come from mips_ctrl_decode.
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       pc_en,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_source,
  output logic [1:0] alu_op,
  output logic       retire,
  output logic       illegal_op,
  output logic [3:0] state
);

  state_t state_q, state_d;
  // lw/sw choice is captured in DECODE so opcode is never looked at later.
  logic   is_sw_q, is_sw_d;

  always_comb begin
    state_d = state_q;
    is_sw_d = is_sw_q;
    unique case (state_q)
      S_FETCH:   if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        is_sw_d = (opcode == OP_SW);
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEM_ADR;
          OP_RTYPE:     state_d = S_EXECUTE;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          OP_ADDI:      state_d = S_ADDI_EX;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEM_ADR: state_d = is_sw_q ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:  if (mem_ready) state_d = S_MEM_WB;
      S_MEM_WR:  if (mem_ready) state_d = S_FETCH;
      S_EXECUTE: state_d = S_ALU_WB;
      S_ADDI_EX: state_d = S_ADDI_WB;
      S_MEM_WB, S_ALU_WB, S_BRANCH, S_JUMP, S_ADDI_WB: state_d = S_FETCH;
      default:   state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      is_sw_q <= 1'b0;
    end else begin
      state_q <= state_d;
      is_sw_q <= is_sw_d;
    end
  end

  assign state = state_q;

  mips_ctrl_decode u_decode (
    .state         (state_q),
    .active        (rst_n),
    .opcode        (opcode),
    .zero          (zero),
    .mem_ready     (mem_ready),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .pc_en         (pc_en),
    .i_or_d        (i_or_d),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .ir_write      (ir_write),
    .mem_to_reg    (mem_to_reg),
    .reg_write     (reg_write),
    .reg_dst       (reg_dst),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .pc_source     (pc_source),
    .alu_op        (alu_op),
    .retire        (retire),
    .illegal_op    (illegal_op)
  );

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Randomized bench for mips_multicycle_ctrl: instruction-level model builds
// the expected state trace and per-state control table.
module tb_mips_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       pc_write, pc_write_cond, pc_en, i_or_d, mem_read, mem_write;
  logic       ir_write, mem_to_reg, reg_write, reg_dst, alu_src_a;
  logic [1:0] alu_src_b, pc_source, alu_op;
  logic       retire, illegal_op;
  logic [3:0] state;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mips_multicycle_ctrl dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_en(pc_en),
    .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write),
    .ir_write(ir_write), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .reg_dst(reg_dst), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .pc_source(pc_source), .alu_op(alu_op), .retire(retire),
    .illegal_op(illegal_op), .state(state)
  );

  wire [18:0] outs = {pc_write, pc_write_cond, pc_en, i_or_d, mem_read, mem_write,
                      ir_write, mem_to_reg, reg_write, reg_dst, alu_src_a,
                      alu_src_b, pc_source, alu_op, retire, illegal_op};

  function automatic bit legal(input logic [5:0] op);
    return op == 6'b000000 || op == 6'b100011 || op == 6'b101011 ||
           op == 6'b000100 || op == 6'b000010 || op == 6'b001000;
  endfunction

  // Control values each state must show, straight from the per-state rules.
  function automatic logic [18:0] exp_outs(input int st, input logic [5:0] op,
                                           input logic z, input logic mr);
    logic pw = 0, pwc = 0, iod = 0, mrd = 0, mwr = 0, irw = 0, m2r = 0;
    logic rw = 0, rd = 0, asa = 0, ret = 0, ill = 0;
    logic [1:0] asb = 2'b00, pcs = 2'b00, aop = 2'b00;
    case (st)
      0:  begin mrd = 1; asb = 2'b01; irw = mr; pw = mr; end
      1:  begin asb = 2'b11; ill = !legal(op); end
      2, 10: begin asa = 1; asb = 2'b10; end
      3:  begin mrd = 1; iod = 1; end
      4:  begin rw = 1; m2r = 1; ret = 1; end
      5:  begin mwr = 1; iod = 1; ret = mr; end
      6:  begin asa = 1; aop = 2'b10; end
      7:  begin rw = 1; rd = 1; ret = 1; end
      8:  begin asa = 1; aop = 2'b01; pwc = 1; pcs = 2'b01; ret = 1; end
      9:  begin pw = 1; pcs = 2'b10; ret = 1; end
      11: begin rw = 1; ret = 1; end
      default: ;
    endcase
    return {pw, pwc, pw | (pwc & z), iod, mrd, mwr, irw, m2r, rw, rd, asa,
            asb, pcs, aop, ret, ill};
  endfunction

  // Run one instruction: fw/mw are wait cycles in FETCH and the data access.
  // abort_at >= 0 stops driving after that cycle index (reset test).
  task automatic run_instr(input logic [5:0] op, input int fw, input int mw,
                           input logic z, input int abort_at,
                           output int n_ret, output int n_mwr, output int n_cyc);
    int sq[$];
    bit mq[$];
    bit aborted = 0;
    for (int k = 0; k < fw; k++) begin sq.push_back(0); mq.push_back(0); end
    sq.push_back(0); mq.push_back(1);
    sq.push_back(1); mq.push_back(1'($urandom));
    case (op)
      6'b100011: begin
        sq.push_back(2); mq.push_back(1'($urandom));
        for (int k = 0; k < mw; k++) begin sq.push_back(3); mq.push_back(0); end
        sq.push_back(3); mq.push_back(1);
        sq.push_back(4); mq.push_back(1'($urandom));
      end
      6'b101011: begin
        sq.push_back(2); mq.push_back(1'($urandom));
        for (int k = 0; k < mw; k++) begin sq.push_back(5); mq.push_back(0); end
        sq.push_back(5); mq.push_back(1);
      end
      6'b000000: begin sq.push_back(6); mq.push_back(1'($urandom));
                       sq.push_back(7); mq.push_back(1'($urandom)); end
      6'b000100: begin sq.push_back(8); mq.push_back(1'($urandom)); end
      6'b000010: begin sq.push_back(9); mq.push_back(1'($urandom)); end
      6'b001000: begin sq.push_back(10); mq.push_back(1'($urandom));
                       sq.push_back(11); mq.push_back(1'($urandom)); end
      default: ;
    endcase
    n_ret = 0; n_mwr = 0; n_cyc = 0;
    foreach (sq[i]) begin
      logic [18:0] e;
      @(negedge clk);
      opcode    = (sq[i] == 1) ? op : 6'($urandom);
      zero      = (sq[i] == 8) ? z : 1'($urandom);
      mem_ready = mq[i];
      #1;
      e = exp_outs(sq[i], opcode, zero, mem_ready);
      n_vec++;
      if (state !== 4'(sq[i]) || outs !== e) begin
        n_err++;
        $display("FAIL cycle op=%b idx=%0d: state=%0d outs=%b, required state=%0d outs=%b",
                 op, i, state, outs, sq[i], e);
      end
      n_cyc++;
      if (retire === 1'b1) n_ret++;
      if (mem_write === 1'b1) n_mwr++;
      if (i == abort_at) begin aborted = 1; break; end
    end
    if (!aborted) begin
      n_vec++;
      if (n_ret != (legal(op) ? 1 : 0)) begin
        n_err++;
        $display("FAIL retire_count op=%b: got %0d, required %0d", op, n_ret, legal(op) ? 1 : 0);
      end
    end
  endtask

  task automatic release_reset();
    @(negedge clk);
    mem_ready = 1'b0;
    #2 rst_n = 1'b1;
    #1;
    n_vec++;
    if (state !== 4'd0 || mem_read !== 1'b1 || outs !== exp_outs(0, opcode, zero, 1'b0)) begin
      n_err++;
      $display("FAIL reset_release: state=%0d mem_read=%b outs=%b, required state=0 mem_read=1",
               state, mem_read, outs);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; opcode = 6'h3f; zero = 1'b1; mem_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    n_vec++;
    if (state !== 4'd0 || outs !== '0) begin
      n_err++;
      $display("FAIL reset_hold: state=%0d outs=%b, required 0 / all zero", state, outs);
    end
    release_reset();
  endtask

  task automatic test_rtype();
    int r, m, c;
    run_instr(6'b000000, 0, 0, 1'b0, -1, r, m, c);
    n_vec++;
    if (c != 4) begin n_err++; $display("FAIL rtype_latency: got %0d, required 4", c); end
  endtask

  task automatic test_lw_wait();
    int r, m, c;
    run_instr(6'b100011, 0, 2, 1'b0, -1, r, m, c);
    n_vec++;
    if (c != 7) begin n_err++; $display("FAIL lw_wait_latency: got %0d, required 7", c); end
  endtask

  task automatic test_beq();
    int r, m, c;
    run_instr(6'b000100, 0, 0, 1'b1, -1, r, m, c);
    run_instr(6'b000100, 0, 0, 1'b0, -1, r, m, c);
    n_vec++;
    if (c != 3) begin n_err++; $display("FAIL beq_latency: got %0d, required 3", c); end
  endtask

  task automatic test_illegal();
    int r, m, c;
    run_instr(6'b111111, 0, 0, 1'b0, -1, r, m, c);
    run_instr(6'b001000, 1, 0, 1'b0, -1, r, m, c);
  endtask

  task automatic test_reset_mid_memwr();
    int r, m, c;
    // sw with a long store wait; abort during the second MEM_WR cycle
    run_instr(6'b101011, 0, 5, 1'b0, 4, r, m, c);
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    if (state !== 4'd0 || outs !== '0 || r != 0) begin
      n_err++;
      $display("FAIL reset_mid_memwr: state=%0d outs=%b retires=%0d, required 0 / zero / 0",
               state, outs, r);
    end
    release_reset();
  endtask

  task automatic test_back_to_back();
    int r1, m1, c1, r2, m2, c2;
    run_instr(6'b101011, 0, 0, 1'b0, -1, r1, m1, c1);
    run_instr(6'b000010, 0, 0, 1'b0, -1, r2, m2, c2);
    n_vec++;
    if (c1 != 4 || c2 != 3 || m1 + m2 != 1 || r1 + r2 != 2) begin
      n_err++;
      $display("FAIL back_to_back: cyc=%0d/%0d mem_write=%0d retire=%0d, required 4/3 1 2",
               c1, c2, m1 + m2, r1 + r2);
    end
  endtask

  task automatic test_random();
    logic [5:0] ops [7];
    int r, m, c;
    ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010, 6'b001000, 6'b000000};
    for (int n = 0; n < 60; n++) begin
      int sel = $urandom_range(0, 6);
      logic [5:0] op = (sel == 6) ? 6'($urandom) : ops[sel];
      run_instr(op, $urandom_range(0, 2), $urandom_range(0, 3), 1'($urandom), -1, r, m, c);
    end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_lw_wait();
    test_beq();
    test_illegal();
    test_reset_mid_memwr();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mips_multicycle_ctrl.md
MIPS_MULTICYCLE_CTRL -- requirements
Module: mips_multicycle_ctrl

Interface
REQ-001 Parameters (name, default, meaning) SHALL be: none; all encodings come from mips_ctrl_pkg.
REQ-002 Ports (name, direction, width, meaning) SHALL be, clock and reset first:
clk  in  1  single clock, rising edge.
rst_n  in  1  reset, asynchronous, active-low.
opcode  in  6  instruction[31:26] from the instruction register.
zero  in  1  ALU zero flag.
mem_ready  in  1  memory completes the current access this cycle.
pc_write  out  1  unconditional PC load.
pc_write_cond  out  1  PC load qualified by zero.
pc_en  out  1  pc_write | (pc_write_cond & zero).
i_or_d  out  1  0 = PC addresses memory, 1 = ALUOut addresses memory.
mem_read  out  1  memory read request.
mem_write  out  1  memory write request.
ir_write  out  1  instruction register load.
mem_to_reg  out  1  1 = MDR to register file.
reg_write  out  1  register file write.
reg_dst  out  1  1 = rd, 0 = rt.
alu_src_a  out  1  0 = PC, 1 = register A.
alu_src_b  out  2  00 = B, 01 = const 4, 10 = sign-ext imm, 11 = sign-ext imm shifted left 2.
pc_source  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target.
alu_op  out  2  to the ALU control decoder: 00 = add, 01 = subtract, 10 = use func.
retire  out  1  one-cycle pulse when an instruction completes.
illegal_op  out  1  one-cycle pulse in DECODE on an unsupported opcode.
state  out  4  current state, debug.
REQ-003 Reset SHALL be asynchronous and active-low on port rst_n, with the single clock on port clk.

Function
REQ-004 The FSM SHALL have states FETCH, DECODE, MEM_ADR, MEM_RD, MEM_WB, MEM_WR, EXECUTE, ALU_WB, BRANCH, JUMP, ADDI_EX, ADDI_WB, encoded 0 to 11.
REQ-005 Supported opcodes SHALL be R-type 000000, lw 100011, sw 101011, beq 000100, j 000010, addi 001000.
REQ-006 FETCH SHALL assert mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00.
REQ-007 In FETCH, ir_write and pc_write SHALL both equal mem_ready; the FSM SHALL stay in FETCH while mem_ready=0 and go to DECODE when mem_ready=1.
REQ-008 DECODE SHALL assert alu_src_a=0, alu_src_b=11, alu_op=00, and SHALL branch on opcode: lw or sw to MEM_ADR, R-type to EXECUTE, beq to BRANCH, j to JUMP, addi to ADDI_EX.
REQ-009 On any other opcode in DECODE, the FSM SHALL pulse illegal_op, leave retire low and return to FETCH.
REQ-010 MEM_ADR and ADDI_EX SHALL assert alu_src_a=1, alu_src_b=10, alu_op=00; MEM_ADR goes to MEM_RD for lw or MEM_WR for sw, and ADDI_EX goes to ADDI_WB.
REQ-011 MEM_RD SHALL assert mem_read=1, i_or_d=1, hold while mem_ready=0, and go to MEM_WB when mem_ready=1.
REQ-012 MEM_WR SHALL assert mem_write=1, i_or_d=1, hold while mem_ready=0, and go to FETCH when mem_ready=1; retire SHALL pulse in that exit cycle.
REQ-013 EXECUTE SHALL assert alu_src_a=1, alu_src_b=00, alu_op=10.
REQ-014 ALU_WB SHALL assert reg_write=1, reg_dst=1, mem_to_reg=0.
REQ-015 MEM_WB SHALL assert reg_write=1, reg_dst=0, mem_to_reg=1.
REQ-016 ADDI_WB SHALL assert reg_write=1, reg_dst=0, mem_to_reg=0.
REQ-017 BRANCH SHALL assert alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01.
REQ-018 JUMP SHALL assert pc_write=1, pc_source=10.
REQ-019 ALU_WB, MEM_WB, ADDI_WB, BRANCH and JUMP SHALL go to FETCH after one cycle and pulse retire in that cycle.
REQ-020 Every output not listed for a state SHALL be 0.
REQ-021 mem_read and mem_write SHALL never be high together, and at most one of reg_write, pc_write or mem_write activity SHALL occur per state.
REQ-022 Inputs opcode and zero SHALL be sampled only in DECODE and BRANCH respectively; mem_ready SHALL be ignored outside FETCH, MEM_RD and MEM_WR.
REQ-023 Latencies SHALL be, with zero-wait memory: R-type 4 cycles, lw 5, sw 4, beq 3, j 3, addi 4; each wait cycle adds 1.

Reset
REQ-024 While rst_n=0 the state SHALL be FETCH and every output SHALL be 0, including state=0.
REQ-025 Reset assertion in any state, including mid memory wait, SHALL abort the instruction immediately with no retire pulse.
REQ-026 After rst_n deasserts, FETCH outputs SHALL appear in the same cycle, and the first state change SHALL occur on the first qualifying clk edge.

Structure
REQ-027 Package mips_ctrl_pkg SHALL hold the state encodings, opcode constants, and alu_op, alu_src_b and pc_source codes.
REQ-028 The state-to-control decode SHALL be a combinational sub-module, mips_ctrl_decode; the top SHALL hold only the state register and next-state logic.

Verification
REQ-029 R-type add, mem_ready=1: states 0,1,6,7,0; alu_op 10 in EXECUTE; reg_write=1 with reg_dst=1 in ALU_WB; retire pulses once.
REQ-030 lw with mem_ready low for 2 cycles in MEM_RD: state sequence 0,1,2,3,3,3,4,0 (7 cycles); i_or_d=1 throughout MEM_RD.
REQ-031 beq with zero=1: pc_en=1 in BRANCH; with zero=0: pc_en=0; both retire after 3 cycles.
REQ-032 opcode 111111: illegal_op pulses in DECODE, next state FETCH, no retire, no reg_write or mem_write.
REQ-033 rst_n pulled low mid MEM_WR wait: all outputs go to 0 asynchronously, no retire; after release, state=0 and mem_read=1.
REQ-034 Back-to-back sw then j, mem_ready=1: sw takes 4 cycles, j 3; mem_write seen exactly 1 cycle; retire count = 2.
